// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and scheduler state encoding
package uart_pkg;
    localparam int UART_BYTE_W = 8;
    localparam int CLK_HZ = 54_000_000;
    localparam int BAUD = 9600;
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx
);
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin packet scheduler sharing one UART byte transmitter
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_ready,
    input  logic                           tx_done,
    output logic [IDW-1:0]                 grant_id,
    output logic                           busy
);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
    state_t state;
    logic last_f;
    logic [IDW-1:0] rr_ptr, arb_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic [GW-1:0] gap_cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr),
        .grant(arb_grant),
        .idx(arb_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            req_ready <= '0;
            tx_start <= 1'b0;
            tx_data <= '0;
            grant_id <= '0;
            busy <= 1'b0;
            last_f <= 1'b0;
            rr_ptr <= '0;
            gap_cnt <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                S_IDLE: if (|arb_grant) begin
                    grant_id <= arb_idx;
                    busy <= 1'b1;
                    state <= S_FETCH;
                end
                S_FETCH: if (req_valid[grant_id]) begin
                    req_ready <= NUM_REQ'(1) << grant_id;
                    tx_data <= req_data[{grant_id, 3'b000} +: UART_BYTE_W];
                    last_f <= req_last[grant_id];
                    tx_start <= 1'b1;
                    state <= S_SEND;
                end
                S_SEND: if (tx_ready) begin
                    tx_start <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: if (tx_done) begin
                    if (!last_f) state <= S_FETCH;
                    else begin
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        busy <= 1'b0;
                        gap_cnt <= '0;
                        state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and table-driven checks of the UART TX scheduler
module tb_uart_tx_scheduler;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] req_valid = '0, req_last = '0, req_ready;
    logic [31:0] req_data = '0;
    logic tx_start, tx_ready, tx_done, busy;
    logic [7:0] tx_data;
    logic [1:0] grant_id;
    logic tx_auto = 1'b0, man_ready = 1'b0, man_done = 1'b0, m_ready = 1'b0, m_done = 1'b0;
    assign tx_ready = tx_auto ? m_ready : man_ready;
    assign tx_done = tx_auto ? m_done : man_done;

    uart_tx_scheduler #(.NUM_REQ(4), .IDW(2), .GAP_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int tcnt = 0, viol = 0, dcnt = 0, scnt = 0, gcnt = 0;
    bit tbusy = 0, busy_q = 0;
    logic [7:0] slog [256];
    logic [1:0] glog [256];
    logic [8:0] pk [4][64];
    int len [4] = '{0, 0, 0, 0};
    int pos [4] = '{0, 0, 0, 0};
    int rdy_cnt [4] = '{0, 0, 0, 0};
    bit hold [4] = '{0, 0, 0, 0};

    // Transmitter model, requester sources and monitors all update on the falling edge
    always @(negedge clk) begin
        m_done = 1'b0;
        if (busy && !busy_q) begin glog[gcnt % 256] = grant_id; gcnt++; end
        busy_q = busy;
        if (req_ready != 4'b0 && (!busy || req_ready != (4'b0001 << grant_id))) viol++;
        if (reset || !tx_auto) begin
            m_ready = 1'b0; tbusy = 0; tcnt = 0;
        end else if (tbusy) begin
            tcnt++;
            if (tcnt == 100) begin m_done = 1'b1; tbusy = 0; tcnt = 0; dcnt++; end
        end else if (m_ready) begin
            m_ready = 1'b0; tbusy = 1; tcnt = 0;
        end else if (tx_start) begin
            tcnt++;
            if (tcnt == 2) begin m_ready = 1'b1; slog[scnt % 256] = tx_data; scnt++; tcnt = 0; end
        end else tcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i] && pos[i] < len[i]) begin pos[i]++; rdy_cnt[i]++; end
            req_valid[i] = (pos[i] < len[i]) && !hold[i];
            req_data[8*i +: 8] = pk[i][pos[i] % 64][7:0];
            req_last[i] = pk[i][pos[i] % 64][8];
        end
    end

    int total = 0, passed = 0;
    int n, bad, early, g0, s0, d0, r0, r1, r3;
    logic [31:0] got, expv;

    typedef struct { logic [3:0] mask; int cnt; logic [7:0] order; } vec_t;
    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        pk[r][len[r] % 64] = {l, d};
        len[r]++;
    endtask

    function automatic bit drained();
        for (int i = 0; i < 4; i++) if (pos[i] != len[i]) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] sent_since(input int s, input int k);
        logic [31:0] v = '0;
        for (int i = 0; i < k; i++) v |= 32'(slog[(s + i) % 256]) << (8 * i);
        return v;
    endfunction

    function automatic logic [31:0] grants_since(input int g, input int k);
        logic [31:0] v = '0;
        for (int i = 0; i < k; i++) v |= 32'(glog[(g + i) % 256]) << (2 * i);
        return v;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int q = 0, c = 0;
        while (q < 20 && c < budget) begin
            tick();
            c++;
            q = (!busy && !tx_start && drained()) ? q + 1 : 0;
        end
        if (q < 20) begin total++; $display("FAIL %s: no idle within %0d cycles", nm, budget); end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin len[i] = pos[i]; hold[i] = 0; end
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0101, 2, 8'h08};
        tbl[1] = '{4'b0101, 2, 8'h08};
        tbl[2] = '{4'b1111, 4, 8'h93};
        tbl[3] = '{4'b1010, 2, 8'h07};
        tbl[4] = '{4'b0011, 2, 8'h04};
        tbl[5] = '{4'b1100, 2, 8'h0E};

        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        man_done = 1'b1; tick();
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_ready", 32'(req_ready), 0);
        man_done = 1'b0; tick();
        chk("idle_done_start", 32'(tx_start), 0);
        r0 = rdy_cnt[2];
        load(2, 8'h5A, 1'b1);
        tick();
        chk("arb_busy", 32'(busy), 1);
        chk("arb_grant", 32'(grant_id), 2);
        chk("arb_no_start", 32'(tx_start), 0);
        tick();
        chk("fetch_start", 32'(tx_start), 1);
        chk("fetch_data", 32'(tx_data), 32'h5A);
        man_done = 1'b1; tick(); man_done = 1'b0; tick(); tick();
        chk("send_done_ignored", 32'(tx_start), 1);
        chk("send_one_ready", 32'(rdy_cnt[2] - r0), 1);
        man_ready = 1'b1; tick(); man_ready = 1'b0;
        chk("accept_drop", 32'(tx_start), 0);
        tick(); tick();
        chk("wait_busy", 32'(busy), 1);
        man_done = 1'b1; tick(); man_done = 1'b0;
        chk("wait_done_release", 32'(busy), 0);
        tx_auto = 1'b1;
        do_reset();

        for (int e = 0; e < 6; e++) begin
            g0 = gcnt; s0 = scnt;
            for (int i = 0; i < 4; i++) if (tbl[e].mask[i]) load(i, 8'h10 + 8'(i), 1'b1);
            wait_idle($sformatf("tbl%0d_idle", e), 3000);
            chk($sformatf("tbl%0d_count", e), 32'(gcnt - g0), 32'(tbl[e].cnt));
            chk($sformatf("tbl%0d_order", e), grants_since(g0, tbl[e].cnt), 32'(tbl[e].order));
            expv = '0;
            for (int k = 0; k < tbl[e].cnt; k++) expv |= (32'h10 + 32'((tbl[e].order >> (2 * k)) & 8'h3)) << (8 * k);
            chk($sformatf("tbl%0d_bytes", e), sent_since(s0, tbl[e].cnt), expv);
        end

        s0 = scnt; d0 = dcnt; r1 = rdy_cnt[1];
        load(1, 8'h41, 1'b0); load(1, 8'h42, 1'b1);
        tick();
        chk("pkt_arb_busy", 32'(busy), 1);
        tick();
        chk("pkt_first_start", 32'(tx_start), 1);
        chk("pkt_first_data", 32'(tx_data), 32'h41);
        n = 0;
        while (!tx_done && n < 300) begin tick(); n++; end
        chk("pkt_done1_seen", 32'(n < 300), 1);
        tick();
        chk("pkt_done_to_start", 32'(tx_start), 1);
        chk("pkt_second_data", 32'(tx_data), 32'h42);
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        chk("pkt_busy_fall_on_done", 32'(tx_done), 1);
        chk("pkt_done_count", 32'(dcnt - d0), 2);
        load(0, 8'h55, 1'b1);
        n = 0;
        while (!busy && n < 40) begin tick(); n++; end
        chk("gap_cycles", 32'(n), 17);
        wait_idle("pkt_idle", 1000);
        chk("pkt_bytes", sent_since(s0, 2), 32'h4241);
        chk("pkt_ready_pulses", 32'(rdy_cnt[1] - r1), 2);

        do_reset();
        s0 = scnt; d0 = dcnt; r1 = rdy_cnt[1]; r3 = rdy_cnt[3]; early = 0; bad = 0; n = 0;
        load(1, 8'hA1, 1'b0); load(1, 8'hA2, 1'b0); load(1, 8'hA3, 1'b1); load(3, 8'hB1, 1'b1);
        while (dcnt - d0 < 3 && n < 1000) begin
            tick(); n++;
            if (rdy_cnt[3] != r3) early++;
            if (busy && grant_id != 2'd1) bad++;
        end
        chk("lock_done_seen", 32'(n < 1000), 1);
        chk("lock_no_early_ready3", 32'(early), 0);
        chk("lock_grant_held", 32'(bad), 0);
        wait_idle("lock_idle", 2000);
        chk("lock_bytes", sent_since(s0, 4), 32'hB1A3A2A1);
        chk("lock_ready1", 32'(rdy_cnt[1] - r1), 3);
        chk("lock_ready3", 32'(rdy_cnt[3] - r3), 1);

        s0 = scnt; d0 = dcnt; r0 = rdy_cnt[0]; r1 = rdy_cnt[1]; bad = 0; n = 0;
        load(0, 8'hC1, 1'b0); load(0, 8'hC2, 1'b0); load(0, 8'hC3, 1'b1); load(1, 8'hD1, 1'b1);
        while (rdy_cnt[0] == r0 && n < 100) begin tick(); n++; end
        hold[0] = 1;
        while (dcnt == d0 && n < 400) begin tick(); n++; end
        chk("stall_done_seen", 32'(n < 400), 1);
        for (int c = 0; c < 50; c++) begin
            tick();
            if (tx_start || !busy || grant_id != 2'd0 || rdy_cnt[1] != r1) bad++;
        end
        chk("stall_held", 32'(bad), 0);
        hold[0] = 0;
        wait_idle("stall_idle", 2000);
        chk("stall_bytes", sent_since(s0, 4), 32'hD1C3C2C1);
        chk("stall_ready0", 32'(rdy_cnt[0] - r0), 3);

        d0 = dcnt; n = 0;
        load(3, 8'hE1, 1'b0); load(3, 8'hE2, 1'b0); load(3, 8'hE3, 1'b0); load(3, 8'hE4, 1'b1);
        while (dcnt == d0 && n < 400) begin tick(); n++; end
        for (int c = 0; c < 20; c++) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_data", 32'(tx_data), 32'hE2);
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_tx_start", 32'(tx_start), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_grant_id", 32'(grant_id), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        do_reset();
        g0 = gcnt;
        load(2, 8'hF2, 1'b1); load(0, 8'hF0, 1'b1);
        wait_idle("post_rst_idle", 2000);
        chk("post_rst_order", grants_since(g0, 2), 32'h08);

        chk("ready_onehot_granted", 32'(viol), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART byte transmitter (8N1, fixed-baud serial TX) between NUM_REQ requesters.
- Requesters submit packets of bytes over valid/ready.
- Round-robin arbitration picks a requester; its grant holds until the packet's last byte has been sent.
- Bytes are handed to the transmitter one at a time, each after the previous frame completes.
- A programmable idle gap is inserted between packets.
- Sits between application logic (status reporters, debug dumpers) and the serial TX module.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, width of grant index, = ceil(log2(NUM_REQ))
GAP_CYCLES, 16, clk cycles of idle line between packets (0 = none)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte, requester i at [8i+7:8i]
req_last  in  NUM_REQ  byte is the final byte of the packet
req_ready  out  NUM_REQ  byte accepted this cycle (one-hot or zero)
tx_start  out  1  request to transmit tx_data, level, held until accepted
tx_data  out  8  byte to transmit, stable while tx_start=1
tx_ready  in  1  transmitter idle; tx_start&tx_ready = byte accepted
tx_done  in  1  one-cycle pulse when the stop bit finishes
grant_id  out  IDW  index of the current owner (valid when busy=1)
busy  out  1  a packet is in progress

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=8'h00, grant_id=0, busy=0. The round-robin pointer resets to 0, meaning requester 0 has highest priority first.
- States: IDLE, FETCH, SEND, WAIT, GAP.
- IDLE:
  - If any req_valid is set, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register grant_id and set busy=1, then go to FETCH next cycle.
  - Arbitration takes 1 cycle and is never combinational to req_ready.
- FETCH:
  - If req_valid[grant_id]=1: pulse req_ready[grant_id] for 1 cycle, latch req_data into tx_data, latch req_last into last_f, assert tx_start, go to SEND.
  - Otherwise stall in FETCH. The grant is held indefinitely until the owner supplies the rest of its packet.
- SEND: hold tx_start and tx_data. In the cycle tx_ready=1, drop tx_start next cycle and go to WAIT.
- WAIT:
  - On tx_done, if last_f=0 go to FETCH.
  - If last_f=1: set rr_ptr=grant_id+1 (wrap), clear busy, go to GAP, or to IDLE when GAP_CYCLES=0.
  - A tx_done in any state other than WAIT is ignored.
- GAP: count GAP_CYCLES clk cycles with tx_start=0, then go to IDLE. New requests are not granted during GAP.
- Latency:
  - IDLE with a request to tx_start high is 2 cycles.
  - tx_done to the next tx_start within the same packet is 2 cycles.
- At most one req_ready bit is high in any cycle, and never for a non-granted requester.
- Simultaneous events:
  - Requests arriving in the same cycle are resolved purely by rr_ptr order.
  - A request from the current owner arriving while in WAIT is only taken in FETCH.
  - Withdrawing req_valid before acceptance is legal. Data must be held while valid=1 and ready=0.
- Single-byte packet (req_last=1 on the first byte) is legal and releases the grant after its frame.
- Reset mid-operation:
  - Aborts immediately; all outputs return to reset values.
  - A byte already handed to the transmitter is not tracked. The transmitter's own reset governs the line.

Decomposition:
- Package uart_pkg holds:
  - the state encoding localparams (S_IDLE..S_GAP, 3-bit);
  - UART_BYTE_W=8;
  - the shared baud constant (54 MHz / 9600 = 5625), reused by the TX module.
- One sub-module: rr_arbiter (NUM_REQ req vector + pointer in, one-hot grant + encoded index out, purely combinational). The FSM, gap counter and data register stay in uart_tx_scheduler.

Test Plan:
- Single requester 1 sends packet {8'h41,8'h42(last)}; the transmitter model returns tx_ready after 2 cycles and tx_done after 100:
  - tx_data shows 8'h41 then 8'h42;
  - exactly 2 req_ready pulses;
  - busy falls on the second tx_done;
  - GAP_CYCLES=16 idle cycles follow before any new grant.
- Requesters 0 and 2 both valid from reset with 1-byte packets: grant order is 0 then 2. The next competition with 0 and 2 valid grants 2 first only if rr_ptr=1..2; check the pointer = 1 after the first packet.
- Burst lock: requester 1 sends a 3-byte packet while requester 3 is continuously valid.
  - No req_ready[3] appears until after requester 1's last tx_done.
  - grant_id stays 1 throughout.
- Owner stalls: req_valid[0] drops for 50 cycles mid-packet. The FSM stays in FETCH, tx_start=0 and the grant is held; the packet resumes with correct bytes.
- Spurious tx_done in IDLE and SEND: no state change and no req_ready.
- Assert reset during WAIT of a 4-byte packet: all outputs go to reset values the same cycle, then after release a fresh arbitration starts from requester 0.
